pwm_timebase: RTL and testbench

- Upstream feeder of the three per-phase dead-time PWM stages in the FOC output path.
- Generates the shared sawtooth carrier `cnt` and, per phase, a centre-aligned compare pair (comp1, comp2). Downstream, each phase is high when comp1 < cnt <= comp2.
- Duty and period updates are double-buffered and applied only at carrier wrap, so a PWM period is never torn.
- Emits an ADC trigger at the centre of the all-low-side-on interval.

---
 rtl/pwm_timebase_pkg.sv | 22 ++
 rtl/pwm_comp_calc.sv | 24 ++
 rtl/pwm_timebase.sv | 181 ++++++++++++++++++
 tb/tb_pwm_timebase.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timebase_pkg.sv
// Shared constants and types for the PWM timebase and the downstream PWM stages.
package pwm_timebase_pkg;

    // Carrier, period, duty and compare width used across the PWM output path.
    localparam int PWM_WIDTH_DEF  = 16;

    // Active period loaded at reset; the carrier runs 0..period inclusive.
    localparam int PERIOD_RST_DEF = 1000;

    // Smallest period an accepted update may install.
    localparam int PERIOD_MIN_DEF = 2;

    // One compare pair per motor phase (A, B, C).
    localparam int NUM_PHASES     = 3;

    // Occupancy of the double-buffer shadow register set.
    typedef enum logic {
        SHADOW_EMPTY = 1'b0,
        SHADOW_FULL  = 1'b1
    } shadow_state_t;

endpackage

// File: rtl/pwm_comp_calc.sv
// Centre-aligned compare pair for one phase: clamps the duty to the period and
// places a window of exactly duty counts centred on period/2.
module pwm_comp_calc
    import pwm_timebase_pkg::*;
#(
    parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
    input  logic [PWM_WIDTH-1:0] period,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic [PWM_WIDTH-1:0] comp1,
    output logic [PWM_WIDTH-1:0] comp2
);

    logic [PWM_WIDTH-1:0] duty_clamped;

    // Clamp duty to period, then split the low time evenly on both sides.
    // With duty <= period the sum comp1 + duty never exceeds period, so no overflow.
    always_comb begin
        duty_clamped = (duty > period) ? period : duty;
        comp1        = (period - duty_clamped) >> 1;
        comp2        = comp1 + duty_clamped;
    end

endmodule

// File: rtl/pwm_timebase.sv
// Shared sawtooth carrier and per-phase compare pairs for the three dead-time
// PWM stages. Period/duty updates are double-buffered and take effect only at
// the carrier wrap, so a PWM period is never torn.
module pwm_timebase
    import pwm_timebase_pkg::*;
#(
    parameter int PWM_WIDTH  = PWM_WIDTH_DEF,
    parameter int PERIOD_RST = PERIOD_RST_DEF,
    parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [PWM_WIDTH-1:0] period,
    input  logic [PWM_WIDTH-1:0] duty_a,
    input  logic [PWM_WIDTH-1:0] duty_b,
    input  logic [PWM_WIDTH-1:0] duty_c,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    output logic [PWM_WIDTH-1:0] cnt,
    output logic [PWM_WIDTH-1:0] comp1_a,
    output logic [PWM_WIDTH-1:0] comp2_a,
    output logic [PWM_WIDTH-1:0] comp1_b,
    output logic [PWM_WIDTH-1:0] comp2_b,
    output logic [PWM_WIDTH-1:0] comp1_c,
    output logic [PWM_WIDTH-1:0] comp2_c,
    output logic                 adc_trig,
    output logic                 update_done
);

    localparam logic [PWM_WIDTH-1:0] PERIOD_RST_V = PWM_WIDTH'(PERIOD_RST);
    localparam logic [PWM_WIDTH-1:0] PERIOD_MIN_V = PWM_WIDTH'(PERIOD_MIN);
    localparam logic [PWM_WIDTH-1:0] CNT_ONE      = PWM_WIDTH'(1);

    // Shadow handshake state
    shadow_state_t state_q;
    shadow_state_t state_d;
    logic          accept;
    logic          apply;
    logic          wrap;

    // Incoming duties gathered per phase
    logic [PWM_WIDTH-1:0] duty_in    [NUM_PHASES];
    logic [PWM_WIDTH-1:0] period_clamped;

    // Shadow set (captured at acceptance) and its derived compares
    logic [PWM_WIDTH-1:0] period_sh;
    logic [PWM_WIDTH-1:0] duty_sh    [NUM_PHASES];
    logic [PWM_WIDTH-1:0] comp1_sh   [NUM_PHASES];
    logic [PWM_WIDTH-1:0] comp2_sh   [NUM_PHASES];

    // Active set and the registered compare outputs
    logic [PWM_WIDTH-1:0] period_act;
    logic [PWM_WIDTH-1:0] comp1_act  [NUM_PHASES];
    logic [PWM_WIDTH-1:0] comp2_act  [NUM_PHASES];
    logic [PWM_WIDTH-1:0] comp1_q    [NUM_PHASES];
    logic [PWM_WIDTH-1:0] comp2_q    [NUM_PHASES];
    logic [PWM_WIDTH-1:0] cnt_q;
    logic                 update_done_q;

    assign duty_in[0] = duty_a;
    assign duty_in[1] = duty_b;
    assign duty_in[2] = duty_c;

    // The shadow is free whenever no update is waiting for the wrap.
    assign duty_ready = (state_q == SHADOW_EMPTY);
    assign accept     = duty_valid && duty_ready;

    // Wrap is the last count of the period; a pending set takes over there.
    assign wrap  = (cnt_q == period_act);
    assign apply = en && wrap && (state_q == SHADOW_FULL);

    // Requested period below the minimum is raised to the minimum.
    assign period_clamped = (period < PERIOD_MIN_V) ? PERIOD_MIN_V : period;

    // Compare pairs are derived combinationally from the shadow set, one per phase.
    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase
        pwm_comp_calc #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_comp_calc (
            .period (period_sh),
            .duty   (duty_sh[g]),
            .comp1  (comp1_sh[g]),
            .comp2  (comp2_sh[g])
        );
    end

    // Shadow occupancy register.
    // NOTE: state is updated with <= so every flop samples pre-edge values; blocking
    // assignments here would make results depend on process evaluation order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SHADOW_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next shadow state: fill on an accepted request, drain on the apply event.
    // NOTE: state_d takes a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHADOW_EMPTY: if (accept) state_d = SHADOW_FULL;
            SHADOW_FULL:  if (apply)  state_d = SHADOW_EMPTY;
            default:      state_d = SHADOW_EMPTY;
        endcase
    end

    // Capture the requested set into the shadow on a completed handshake.
    // NOTE: the shadow data is deliberately not reset; it is only ever consumed
    // while the state says SHADOW_FULL, and reset clears that flag.
    always_ff @(posedge clk) begin
        if (accept) begin
            period_sh <= period_clamped;
            for (int i = 0; i < NUM_PHASES; i++) begin
                duty_sh[i] <= duty_in[i];
            end
        end
    end

    // Carrier, active set and registered compare outputs, all on the same edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q         <= '0;
            period_act    <= PERIOD_RST_V;
            update_done_q <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                comp1_act[i] <= '0;
                comp2_act[i] <= '0;
                comp1_q[i]   <= '0;
                comp2_q[i]   <= '0;
            end
        end else begin
            update_done_q <= apply;

            if (!en || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end

            if (apply) begin
                period_act <= period_sh;
            end

            for (int i = 0; i < NUM_PHASES; i++) begin
                if (apply) begin
                    comp1_act[i] <= comp1_sh[i];
                    comp2_act[i] <= comp2_sh[i];
                end
                // Parked carrier forces every phase to its low side.
                if (!en) begin
                    comp1_q[i] <= '0;
                    comp2_q[i] <= '0;
                end else if (apply) begin
                    comp1_q[i] <= comp1_sh[i];
                    comp2_q[i] <= comp2_sh[i];
                end else begin
                    comp1_q[i] <= comp1_act[i];
                    comp2_q[i] <= comp2_act[i];
                end
            end
        end
    end

    // ADC sample point: centre of the all-low-side interval, i.e. cnt == 0 while
    // running. It follows en directly so it fires on the first enabled cycle.
    assign adc_trig    = rstn && en && (cnt_q == '0);

    assign cnt         = cnt_q;
    assign update_done = update_done_q;
    assign comp1_a     = comp1_q[0];
    assign comp2_a     = comp2_q[0];
    assign comp1_b     = comp1_q[1];
    assign comp2_b     = comp2_q[1];
    assign comp1_c     = comp1_q[2];
    assign comp2_c     = comp2_q[2];

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: an integer-level model of the carrier and
// double-buffered update rules is compared against the DUT every cycle, and
// hand-computed literals pin the model at the key points.
module tb_pwm_timebase;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic [W-1:0] period;
    logic [W-1:0] duty_a;
    logic [W-1:0] duty_b;
    logic [W-1:0] duty_c;
    logic         duty_valid;
    logic         duty_ready;
    logic [W-1:0] cnt;
    logic [W-1:0] comp1_a;
    logic [W-1:0] comp2_a;
    logic [W-1:0] comp1_b;
    logic [W-1:0] comp2_b;
    logic [W-1:0] comp1_c;
    logic [W-1:0] comp2_c;
    logic         adc_trig;
    logic         update_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_timebase dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .period      (period),
        .duty_a      (duty_a),
        .duty_b      (duty_b),
        .duty_c      (duty_c),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .cnt         (cnt),
        .comp1_a     (comp1_a),
        .comp2_a     (comp2_a),
        .comp1_b     (comp1_b),
        .comp2_b     (comp2_b),
        .comp1_c     (comp1_c),
        .comp2_c     (comp2_c),
        .adc_trig    (adc_trig),
        .update_done (update_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int f_c1(input int p, input int d);
        int dd;
        dd = (d > p) ? p : d;
        return (p - dd) / 2;
    endfunction

    function automatic int f_c2(input int p, input int d);
        int dd;
        dd = (d > p) ? p : d;
        return f_c1(p, d) + dd;
    endfunction

    int m_cnt, m_pact, m_sh_p, m_upd;
    bit m_pending;
    int m_sh_d [3];
    int m_c1   [3];
    int m_c2   [3];
    int m_o1   [3];
    int m_o2   [3];
    bit m_apply, m_accept;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_cnt     = 0;
            m_pact    = 1000;
            m_pending = 1'b0;
            m_upd     = 0;
            for (int i = 0; i < 3; i++) begin
                m_c1[i] = 0; m_c2[i] = 0; m_o1[i] = 0; m_o2[i] = 0;
            end
        end else begin
            m_apply  = en && (m_cnt == m_pact) && m_pending;
            m_accept = duty_valid && !m_pending;
            if (!en || m_cnt == m_pact) m_cnt = 0;
            else                        m_cnt = m_cnt + 1;
            m_upd = m_apply ? 1 : 0;
            if (m_apply) begin
                m_pact = m_sh_p;
                for (int i = 0; i < 3; i++) begin
                    m_c1[i] = f_c1(m_sh_p, m_sh_d[i]);
                    m_c2[i] = f_c2(m_sh_p, m_sh_d[i]);
                end
                m_pending = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                m_o1[i] = en ? m_c1[i] : 0;
                m_o2[i] = en ? m_c2[i] : 0;
            end
            if (m_accept) begin
                m_pending = 1'b1;
                m_sh_p    = (int'(period) < 2) ? 2 : int'(period);
                m_sh_d[0] = int'(duty_a);
                m_sh_d[1] = int'(duty_b);
                m_sh_d[2] = int'(duty_c);
            end
        end
        model_live = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cnt",         cnt,         m_cnt);
            check("comp1_a",     comp1_a,     m_o1[0]);
            check("comp2_a",     comp2_a,     m_o2[0]);
            check("comp1_b",     comp1_b,     m_o1[1]);
            check("comp2_b",     comp2_b,     m_o2[1]);
            check("comp1_c",     comp1_c,     m_o1[2]);
            check("comp2_c",     comp2_c,     m_o2[2]);
            check("adc_trig",    adc_trig,    (en && rstn && m_cnt == 0));
            check("update_done", update_done, m_upd);
            check("duty_ready",  duty_ready,  !m_pending);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (cnt == W'(target)) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_update(input int budget, input string name, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (update_done) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic set_req(input int p, input int a, input int b, input int c);
        period     = W'(p);
        duty_a     = W'(a);
        duty_b     = W'(b);
        duty_c     = W'(c);
        duty_valid = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int high_cnt;
    int n;
    int pulses;
    int max_cnt;

    initial begin
        rstn = 1'b0; en = 1'b0; duty_valid = 1'b0;
        period = '0; duty_a = '0; duty_b = '0; duty_c = '0;

        // Reset state
        @(posedge clk); #2;
        @(negedge clk);
        check("rst_cnt",         cnt,         0);
        check("rst_comp2_a",     comp2_a,     0);
        check("rst_ready",       duty_ready,  1);
        check("rst_update_done", update_done, 0);
        check("rst_adc",         adc_trig,    0);

        // Free-running carrier with the reset period
        step(); rstn = 1'b1; en = 1'b1;
        @(negedge clk);
        check("first_adc", adc_trig, 1);
        check("first_cnt", cnt,      0);
        wait_cnt(1000, 1100, "reach_1000");
        @(negedge clk);
        check("wrap_cnt_1000", cnt,      0);
        check("wrap_adc_1000", adc_trig, 1);
        check("idle_comp2_c",  comp2_c,  0);

        // Mid-period update, then a second request while pending
        repeat (9) step();
        set_req(100, 40, 0, 100);
        @(negedge clk);
        check("ready_before_accept", duty_ready, 1);
        step(); set_req(7, 3, 3, 3);
        @(negedge clk);
        check("ready_while_pending", duty_ready, 0);
        repeat (4) step();
        duty_valid = 1'b0;

        // Request on the apply cycle applies one period later
        wait_cnt(1000, 1100, "reach_wrap_for_update");
        step(); set_req(1, 1, 3, 0);
        @(negedge clk);
        check("upd1_done", update_done, 1);
        check("upd1_cnt",  cnt,         0);
        check("upd1_adc",  adc_trig,    1);
        check("upd1_ready", duty_ready, 1);
        check("upd1_c1a", comp1_a, 30);
        check("upd1_c2a", comp2_a, 70);
        check("upd1_c1b", comp1_b, 50);
        check("upd1_c2b", comp2_b, 50);
        check("upd1_c1c", comp1_c, 0);
        check("upd1_c2c", comp2_c, 100);
        high_cnt = 0;
        step(); duty_valid = 1'b0;
        @(negedge clk);
        check("ready_after_apply_accept", duty_ready, 0);
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (comp1_a < cnt && cnt <= comp2_a) high_cnt++;
        end
        check("phase_a_high_width", high_cnt, 40);

        @(negedge clk);
        check("upd2_done", update_done, 1);
        check("upd2_cnt",  cnt,         0);
        check("upd2_c1a",  comp1_a,     0);
        check("upd2_c2a",  comp2_a,     1);
        check("upd2_c1b",  comp1_b,     0);
        check("upd2_c2b",  comp2_b,     2);
        check("upd2_c1c",  comp1_c,     1);
        check("upd2_c2c",  comp2_c,     1);
        repeat (3) @(negedge clk);
        check("period_min_wrap", cnt, 0);

        // Duty above period is clamped to the period
        step(); set_req(100, 150, 50, 99);
        step(); duty_valid = 1'b0;
        wait_update(20, "clamp_update_seen", n);
        check("clamp_c1a", comp1_a, 0);
        check("clamp_c2a", comp2_a, 100);
        check("clamp_c1b", comp1_b, 25);
        check("clamp_c2b", comp2_b, 75);
        check("clamp_c1c", comp1_c, 0);
        check("clamp_c2c", comp2_c, 99);

        // en dropped mid-period with an update pending
        step(); set_req(50, 10, 20, 30);
        step(); duty_valid = 1'b0;
        wait_cnt(56, 200, "reach_56");
        step(); en = 1'b0;
        @(negedge clk);
        check("drop_cnt_57", cnt,      57);
        check("drop_adc_57", adc_trig, 0);
        @(negedge clk);
        check("parked_cnt",     cnt,        0);
        check("parked_comp2_a", comp2_a,    0);
        check("parked_adc",     adc_trig,   0);
        check("parked_ready",   duty_ready, 0);
        repeat (4) @(negedge clk);
        step(); en = 1'b1;
        @(negedge clk);
        check("reenable_adc", adc_trig, 1);
        check("reenable_cnt", cnt,      0);
        wait_update(300, "reenable_update_seen", n);
        check("reenable_apply_delay", n, 101);
        check("re_c1a", comp1_a, 20);
        check("re_c2a", comp2_a, 30);
        check("re_c1b", comp1_b, 15);
        check("re_c2b", comp2_b, 35);
        check("re_c1c", comp1_c, 10);
        check("re_c2c", comp2_c, 40);

        // Reset while an update is pending drops it
        step(); set_req(30, 5, 5, 5);
        step(); duty_valid = 1'b0; rstn = 1'b0;
        step();
        @(negedge clk);
        check("rst2_ready",   duty_ready,  1);
        check("rst2_cnt",     cnt,         0);
        check("rst2_comp2_b", comp2_b,     0);
        check("rst2_done",    update_done, 0);
        check("rst2_adc",     adc_trig,    0);
        step(); rstn = 1'b1;
        pulses  = 0;
        max_cnt = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (update_done) pulses++;
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
        check("stale_update_pulses", pulses,  0);
        check("rst2_period_max",     max_cnt, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
